// File: rtl/multipler_arbiter.sv
// multipler_arbiter: round-robin sharing of one iterative multiplier among NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining MULARB_TIMEOUT_EN.
module multipler_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_LENGTH    = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [2*DATA_LENGTH-1:0]         result_o,
    output logic                             err_o,
    output logic                             busy_o,
    output logic                             mul_start_o,
    output logic [DATA_LENGTH-1:0]           mul_a_o,
    output logic [DATA_LENGTH-1:0]           mul_b_o,
    input  logic                             mul_busy_i,
    input  logic                             mul_finish_i,
    input  logic [2*DATA_LENGTH-1:0]         mul_r_i
);
    // state | meaning
    // IDLE  | waiting for a pending request and an idle multiplier
    // ISSUE | start pulse to the multiplier, grant pulse to the winner
    // WAIT  | operands held, waiting for the multiplier finish (or timeout)
    // RESP  | done pulse and product returned to the winner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         last_ptr_q;
    logic [PTR_W-1:0]         win_q;
    logic [PTR_W-1:0]         win_d;
    logic [PTR_W:0]           cand;
    logic                     win_found;
    logic                     issue_ok;
    logic                     timeout_hit;
    logic [NUM_REQ-1:0]       win_onehot;
    logic [DATA_LENGTH-1:0]   a_q, b_q;
    logic [2*DATA_LENGTH-1:0] result_q;

    // Search starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        win_found = 1'b0;
        win_d     = last_ptr_q;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && req_i[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_d     = cand[PTR_W-1:0];
            end
        end
    end

    // A finish pulse in IDLE belongs to an abandoned run; wait for it to clear too.
    assign issue_ok = win_found && !mul_busy_i && !mul_finish_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue_ok) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mul_finish_i || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_ptr_q <= PTR_W'(NUM_REQ - 1);
            win_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && issue_ok) begin
                win_q <= win_d;
                a_q   <= req_a_i[win_d*DATA_LENGTH +: DATA_LENGTH];
                b_q   <= req_b_i[win_d*DATA_LENGTH +: DATA_LENGTH];
            end
            if (state_q == ISSUE) begin
                last_ptr_q <= win_q;
            end
            if (state_q == WAIT && mul_finish_i) begin
                result_q <= mul_r_i;
            end else if (timeout_hit) begin
                result_q <= '0;
            end
        end
    end

`ifdef MULARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;

    // Down-counter loaded on the way into WAIT; terminal count ends the wait.
    assign timeout_hit = (state_q == WAIT) && !mul_finish_i && (tmo_cnt_q == TMO_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES);
                err_q     <= 1'b0;
            end else if (state_q == WAIT) begin
                if (tmo_cnt_q != '0) tmo_cnt_q <= tmo_cnt_q - 1'b1;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    assign err_o = (state_q == RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    assign win_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
    assign busy_o      = (state_q != IDLE);
    assign mul_start_o = (state_q == ISSUE);
    assign gnt_o       = (state_q == ISSUE) ? win_onehot : '0;
    assign done_o      = (state_q == RESP) ? win_onehot : '0;
    assign result_o    = (state_q == RESP) ? result_q : '0;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;

endmodule

// File: tb/tb_multipler_arbiter.sv
// tb_multipler_arbiter: scoreboard bench for multipler_arbiter with a behavioural iterative multiplier.
// Timeout scenario runs only when MULARB_TIMEOUT_EN is defined.
module tb_multipler_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DL      = 64;
    localparam int TMO     = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [NUM_REQ-1:0]    req_i = '0;
    logic [NUM_REQ*DL-1:0] req_a_i = '0;
    logic [NUM_REQ*DL-1:0] req_b_i = '0;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    done_o;
    logic [2*DL-1:0]       result_o;
    logic                  err_o;
    logic                  busy_o;
    logic                  mul_start_o;
    logic [DL-1:0]         mul_a_o;
    logic [DL-1:0]         mul_b_o;
    logic                  mul_busy_i = 1'b0;
    logic                  mul_finish_i = 1'b0;
    logic [2*DL-1:0]       mul_r_i = '0;

    multipler_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_LENGTH   (DL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mul_start_o (mul_start_o),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_busy_i  (mul_busy_i),
        .mul_finish_i(mul_finish_i),
        .mul_r_i     (mul_r_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural multiplier: product taken from the operand bus at finish time.
    int mul_lat   = 5;
    bit mul_stall = 1'b0;
    int mul_cnt   = 0;

    always @(posedge clk_i) begin
        mul_finish_i <= 1'b0;
        if (mul_start_o && !mul_busy_i) begin
            mul_busy_i <= 1'b1;
            mul_cnt    <= mul_lat;
        end else if (mul_busy_i && !mul_stall) begin
            if (mul_cnt <= 1) begin
                mul_busy_i   <= 1'b0;
                mul_finish_i <= 1'b1;
                mul_r_i      <= {{DL{1'b0}}, mul_a_o} * {{DL{1'b0}}, mul_b_o};
            end else begin
                mul_cnt <= mul_cnt - 1;
            end
        end
    end

    typedef struct {
        int            idx;
        logic [2*DL-1:0] r;
        logic          err;
    } exp_t;

    int            gnt_q[$];
    exp_t          res_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            fin_cyc  = -100;
    int            gnt_cyc  = -1;
    int            done_cyc = -1;
    int            req_cyc  = 0;
    int            remaining[NUM_REQ];
    bit            mod_a_on_gnt = 1'b0;
    bit            hold_chk     = 1'b0;
    logic [DL-1:0] orig_a;

    task automatic check_eq(input string tag, input logic [2*DL-1:0] act, input logic [2*DL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_op(input int idx, input logic [DL-1:0] a, input logic [DL-1:0] b);
        exp_t e;
        logic [2*DL-1:0] ax, bx;
        req_a_i[idx*DL +: DL] = a;
        req_b_i[idx*DL +: DL] = b;
        ax = {{DL{1'b0}}, a};
        bx = {{DL{1'b0}}, b};
        e.idx = idx;
        e.r   = ax * bx;
        e.err = 1'b0;
        gnt_q.push_back(idx);
        res_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        int   g;
        @(negedge clk_i);
        cyc++;
        if (mul_finish_i) fin_cyc = cyc;
        if (mul_start_o && mul_busy_i) check_eq("start_while_busy", 1, 0);
        if (gnt_o != '0 && done_o != '0) check_eq("gnt_done_overlap", {gnt_o, done_o}, 0);
        if (gnt_o != '0 || mul_start_o) begin
            check_eq("start_with_gnt", {mul_start_o, |gnt_o}, 2'b11);
            if (gnt_q.size() == 0) begin
                check_eq("gnt_unexpected", gnt_o, 0);
            end else begin
                g = gnt_q.pop_front();
                check_eq("gnt_onehot", gnt_o, 1 << g);
                gnt_cyc = cyc;
                if (mod_a_on_gnt) begin
                    orig_a = req_a_i[g*DL +: DL];
                    req_a_i[g*DL +: DL] = 64'd9;
                    mod_a_on_gnt = 1'b0;
                end
            end
        end
        if (done_o != '0) begin
            done_cyc = cyc;
            if (res_q.size() == 0) begin
                check_eq("done_unexpected", done_o, 0);
            end else begin
                e = res_q.pop_front();
                check_eq("done_onehot", done_o, 1 << e.idx);
                check_eq("result", result_o, e.r);
                check_eq("err", err_o, e.err);
                if (!e.err) check_eq("done_latency", cyc - fin_cyc, 1);
                if (hold_chk) begin
                    check_eq("mul_a_hold", mul_a_o, orig_a);
                    hold_chk = 1'b0;
                end
                if (remaining[e.idx] > 0) remaining[e.idx]--;
                if (remaining[e.idx] == 0) req_i[e.idx] = 1'b0;
            end
        end else if (result_o != '0) begin
            check_eq("result_outside_resp", result_o, 0);
        end
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while ((gnt_q.size() != 0 || res_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", gnt_q.size() + res_q.size(), 0);
        step();
        step();
        check_eq("idle_after", busy_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc += 2;
        gnt_q.delete();
        res_q.delete();
        for (int k = 0; k < NUM_REQ; k++) remaining[k] = 0;
    endtask

    initial begin
        exp_t e;
        int   n;

        // Reset state
        do_reset();
        check_eq("rst_ctrl", {busy_o, mul_start_o, err_o, gnt_o, done_o}, 0);
        check_eq("rst_result", result_o, 0);
        check_eq("rst_mul_a", mul_a_o, 0);
        check_eq("rst_mul_b", mul_b_o, 0);

        // Single request with latency check
        expect_op(0, 64'd3, 64'd5);
        remaining[0] = 1;
        req_i   = 4'b0001;
        req_cyc = cyc;
        run_until_empty(100);
        check_eq("gnt_latency", gnt_cyc - req_cyc, 1);

        // Round-robin with all requesters held
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) expect_op(k, 64'(k + 2), 64'd7);
        expect_op(0, 64'd2, 64'd7);
        remaining[0] = 2;
        for (int k = 1; k < NUM_REQ; k++) remaining[k] = 1;
        req_i = 4'b1111;
        run_until_empty(400);

        // Priority after requester 1 served
        do_reset();
        expect_op(1, 64'd6, 64'd7);
        remaining[1] = 1;
        req_i = 4'b0010;
        run_until_empty(100);
        expect_op(0, 64'd10, 64'd11);
        expect_op(1, 64'd12, 64'd13);
        remaining[0] = 1;
        remaining[1] = 1;
        req_i = 4'b0011;
        run_until_empty(200);

        // Operand stability: requester changes a right at its grant
        expect_op(2, 64'd5, 64'd6);
        remaining[2] = 1;
        mod_a_on_gnt = 1'b1;
        hold_chk     = 1'b1;
        req_i = 4'b0100;
        run_until_empty(100);

        // Maximum-width operands
        req_a_i[3*DL +: DL] = '1;
        req_b_i[3*DL +: DL] = '1;
        gnt_q.push_back(3);
        e.idx = 3;
        e.r   = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        e.err = 1'b0;
        res_q.push_back(e);
        remaining[3] = 1;
        req_i = 4'b1000;
        run_until_empty(100);

        // Reset while WAIT with a stalled multiplier
        mul_stall = 1'b1;
        req_a_i[2*DL +: DL] = 64'd7;
        req_b_i[2*DL +: DL] = 64'd8;
        gnt_q.push_back(2);
        remaining[2] = 1;
        req_i = 4'b0100;
        n = 0;
        while (gnt_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check_eq("abort_gnt_seen", gnt_q.size(), 0);
        repeat (3) step();
        check_eq("busy_in_wait", busy_o, 1);
        do_reset();
        expect_op(1, 64'd11, 64'd13);
        remaining[1] = 1;
        req_i = 4'b0010;
        repeat (6) step();
        check_eq("no_start_while_busy", gnt_q.size(), 1);
        mul_stall = 1'b0;
        run_until_empty(200);

`ifdef MULARB_TIMEOUT_EN
        // Stalled finish runs into the WAIT timeout
        mul_stall = 1'b1;
        req_a_i[3*DL +: DL] = 64'd2;
        req_b_i[3*DL +: DL] = 64'd2;
        gnt_q.push_back(3);
        e.idx = 3;
        e.r   = '0;
        e.err = 1'b1;
        res_q.push_back(e);
        remaining[3] = 1;
        req_i = 4'b1000;
        run_until_empty(100);
        check_eq("timeout_len", done_cyc - gnt_cyc, TMO + 1);
        mul_stall = 1'b0;
        repeat (10) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multipler_arbiter.md
Name: multipler_arbiter

Overview:
- Shares one iterative `multipler_top` instance between NUM_REQ requesters.
- Arbitrates round-robin among pending requests and latches the winner's operands.
- Issues a one-cycle start to the multiplier, waits for its finish pulse, then returns the product to the winner with a one-cycle done strobe.
- Sits between the requester blocks and the multiplier; the multiplier's own start/busy/finish/operand/result ports connect directly to the mul_* ports below.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_LENGTH, 64, operand width; must equal the multiplier's DATA_LENGTH.
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit. Used only when MULARB_TIMEOUT_EN is defined.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level.
- req_a_i  input  NUM_REQ*DATA_LENGTH  packed operand a; slice k = [k*DATA_LENGTH +: DATA_LENGTH].
- req_b_i  input  NUM_REQ*DATA_LENGTH  packed operand b; same slicing.
- gnt_o  output  NUM_REQ  one-hot, one-cycle grant pulse; operands have been taken.
- done_o  output  NUM_REQ  one-hot, one-cycle completion pulse.
- result_o  output  2*DATA_LENGTH  product; valid while any done_o bit is high.
- err_o  output  1  timeout flag, qualifies done_o. Tied 0 without MULARB_TIMEOUT_EN.
- busy_o  output  1  high whenever state is not IDLE.
- mul_start_o  output  1  start pulse to the multiplier.
- mul_a_o  output  DATA_LENGTH  latched operand a to the multiplier.
- mul_b_o  output  DATA_LENGTH  latched operand b to the multiplier.
- mul_busy_i  input  1  multiplier busy.
- mul_finish_i  input  1  multiplier finish pulse.
- mul_r_i  input  2*DATA_LENGTH  multiplier result.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - last_ptr = NUM_REQ-1, so requester 0 has highest priority after reset.
  - All outputs 0; operand and result registers 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Transitions to ISSUE when |req_i = 1, mul_busy_i = 0 and mul_finish_i = 0.
  - The winner is the first set req_i bit searching last_ptr+1, last_ptr+2, … modulo NUM_REQ.
  - On that edge: latch winner index, req_a_i slice → mul_a_o, req_b_i slice → mul_b_o.
- ISSUE (exactly 1 cycle):
  - mul_start_o = 1 and gnt_o[winner] = 1.
  - last_ptr ← winner. Next state is WAIT.
  - The requester may drop req_i or change operands from the next cycle on.
- WAIT:
  - mul_a_o / mul_b_o are held stable.
  - On mul_finish_i = 1: capture mul_r_i into the result register and go to RESP.
- RESP (exactly 1 cycle):
  - done_o[winner] = 1 and result_o = captured product. Next state is IDLE.
  - result_o is 0 outside RESP.
- Latency (no contention, multiplier idle):
  - req_i sampled high at edge t → gnt_o and mul_start_o high in cycle t+1.
  - done_o is high in the cycle after the cycle in which mul_finish_i is high.
- Minimum spacing: back-to-back grants are separated by the full operation plus 3 cycles (ISSUE, RESP, IDLE).
- req_i semantics:
  - A requester holding req_i high through its own RESP cycle is re-eligible in the following IDLE.
  - Because of round-robin, it wins again only if no other request is pending.
  - req_i deasserted before its grant simply withdraws the request; no grant is issued.
- Reset mid-operation:
  - Return to IDLE with no done_o issued for the in-flight request.
  - The in-flight multiplier run is left to complete; its finish is ignored.
  - The IDLE issue condition (mul_busy_i = 0 and mul_finish_i = 0) blocks a new start until the multiplier is idle.
- Stray mul_finish_i while in IDLE or ISSUE: ignored.
- gnt_o and done_o are never asserted in the same cycle.
- mul_start_o is asserted only in ISSUE.

Optional Feature:
- Macro MULARB_TIMEOUT_EN.
- Defined:
  - A WAIT-state cycle counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without mul_finish_i, go to RESP with result 0 and err_o = 1 for that RESP cycle.
  - IDLE issue then waits until mul_busy_i = 0.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - err_o is constant 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- Single request: reset, req_i = 4'b0001, a = 3, b = 5.
  → gnt_o = 0001 one cycle after the sample edge, with mul_start_o high in the same cycle.
  → done_o = 0001, result_o = 15 one cycle after mul_finish_i; busy_o low afterwards.
- Round-robin: hold req_i = 4'b1111; requester k uses a = k+2, b = 7.
  → grant order 0, 1, 2, 3, 0.
  → results 14, 21, 28, 35, 14 on the matching done_o bit.
- Mid-ptr priority: after requester 1 is served, req_i = 4'b0011.
  → requester 0 wins before requester 1.
- Max width: a = b = 2^64-1 → result_o = 2^128 - 2^65 + 1.
- Operand stability: change req_a_i of the granted requester to 9 in the cycle after gnt_o.
  → mul_a_o unchanged until RESP; result uses the original a.
- Reset in WAIT: assert rst_i for 1 cycle while the multiplier is busy, then req_i = 0010.
  → no done_o for the old request; no mul_start_o until mul_busy_i = 0; requester 1 then completes correctly.
  → With MULARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a stalled finish gives done_o, err_o = 1, result_o = 0 after 8 WAIT cycles.
